// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: main slot plus one skid slot with a valid/ready handshake,
// a synchronous flush, and NOP bubbles on empty. Define IFID_PERF_CNT_EN to add perf counters.
module if_id_skid_reg #(
  parameter int               INS_ADDRESS = 9,
  parameter int               INS_W       = 32,
  parameter logic [INS_W-1:0] NOP_INSN    = INS_W'(32'h0000_0013)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INS_W-1:0]       in_inst,
  input  logic [INS_ADDRESS-1:0] in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INS_W-1:0]       out_inst,
  output logic [INS_ADDRESS-1:0] out_pc
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0]            stall_cycles,
  output logic [15:0]            flush_count
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_in_ready;
  logic [INS_W-1:0]       r_main_inst;
  logic [INS_ADDRESS-1:0] r_main_pc;
  logic [INS_W-1:0]       r_skid_inst;
  logic [INS_ADDRESS-1:0] r_skid_pc;

  logic w_out_valid;
  logic w_accept;
  logic w_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = in_valid & r_in_ready;
  assign w_fire      = w_out_valid & out_ready;

  // Main takes fresh input when it is empty or being drained this cycle;
  // otherwise an accepted word parks in the skid slot.
  assign w_load_main_in   = w_accept & ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_fire));
  assign w_load_skid      = w_accept & (r_state == S_ONE) & ~w_fire;
  assign w_load_main_skid = (r_state == S_TWO) & w_fire;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_accept && !w_fire)      w_state_nxt = S_TWO;
        else if (!w_accept && w_fire) w_state_nxt = S_EMPTY;
      end
      S_TWO:   if (w_fire) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
    end
  end

  // NOTE: payload registers are not reset; the valid state gates them to NOP/0 on the outputs.
  always_ff @(posedge clk) begin
    if (w_load_main_in) begin
      r_main_inst <= in_inst;
      r_main_pc   <= in_pc;
    end else if (w_load_main_skid) begin
      r_main_inst <= r_skid_inst;
      r_main_pc   <= r_skid_pc;
    end
    if (w_load_skid) begin
      r_skid_inst <= in_inst;
      r_skid_pc   <= in_pc;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_inst  = w_out_valid ? r_main_inst : NOP_INSN;
  assign out_pc    = w_out_valid ? r_main_pc : '0;

`ifdef IFID_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  // Saturating counters; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_out_valid && !out_ready && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (flush && (r_flush_count != 16'hFFFF))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg; the counter checks build only
// when IFID_PERF_CNT_EN is defined.
module tb_if_id_skid_reg;

  localparam int         AW  = 9;
  localparam int         IW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_inst;
  logic [AW-1:0] in_pc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_inst;
  logic [AW-1:0] out_pc;
`ifdef IFID_PERF_CNT_EN
  logic [15:0]   stall_cycles;
  logic [15:0]   flush_count;
`endif

  int errors = 0;
  int checks = 0;

  if_id_skid_reg #(.INS_ADDRESS(AW), .INS_W(IW), .NOP_INSN(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [AW-1:0] pc);
    return 32'hA500_0000 | 32'(pc);
  endfunction

  task automatic drive(input logic v, input logic [AW-1:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst_of(pc);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b0, '0);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_inst !== NOP) begin errors++; $display("FAIL reset_out_inst: got %h want %h", out_inst, NOP); end
    checks++; if (out_pc !== '0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, AW'(i));
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== AW'(i) || out_inst !== inst_of(AW'(i))) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, AW'(i), inst_of(AW'(i)));
      end
    end
    drive(1'b0, '0);
    tick();
    checks++; if (out_valid !== 1'b0 || out_inst !== NOP) begin errors++; $display("FAIL stream_drain: got v=%b inst=%h want v=0 inst=%h", out_valid, out_inst, NOP); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive(1'b1, 9'd4); tick();
    drive(1'b1, 9'd5); tick();
    checks++; if (out_pc !== 9'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL skid_fill: got pc=%h rdy=%b want pc=004 rdy=0", out_pc, in_ready); end
    drive(1'b1, 9'd6); tick();
    checks++; if (out_pc !== 9'd4 || out_inst !== inst_of(9'd4) || in_ready !== 1'b0) begin errors++; $display("FAIL skid_hold: got pc=%h inst=%h rdy=%b want pc=004 rdy=0", out_pc, out_inst, in_ready); end
    out_ready = 1'b1; tick();
    checks++; if (out_pc !== 9'd5 || out_inst !== inst_of(9'd5) || in_ready !== 1'b1) begin errors++; $display("FAIL skid_pop5: got pc=%h inst=%h rdy=%b want pc=005 rdy=1", out_pc, out_inst, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 9'd6) begin errors++; $display("FAIL skid_pop6: got v=%b pc=%h want v=1 pc=006", out_valid, out_pc); end
    drive(1'b0, '0); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty: got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
`ifdef IFID_PERF_CNT_EN
    logic [15:0] f0 = flush_count;
`endif
    out_ready = 1'b0;
    drive(1'b1, 9'd7); tick();
    drive(1'b1, 9'd8); tick();
    checks++; if (in_ready !== 1'b0 || out_pc !== 9'd7) begin errors++; $display("FAIL flush_two_setup: got rdy=%b pc=%h want rdy=0 pc=007", in_ready, out_pc); end
    flush = 1'b1; drive(1'b1, 9'd9); tick();
    flush = 1'b0; drive(1'b0, '0);
    checks++; if (out_valid !== 1'b0 || out_inst !== NOP || out_pc !== '0) begin errors++; $display("FAIL flush_two: got v=%b inst=%h pc=%h want v=0 inst=%h pc=0", out_valid, out_inst, out_pc, NOP); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_pc9: got v=%b pc=%h want v=0", out_valid, out_pc); end
    // Flush from ONE while a word is accepted: that word must vanish too.
    out_ready = 1'b0;
    drive(1'b1, 9'd10); tick();
    flush = 1'b1; drive(1'b1, 9'd11); tick();
    flush = 1'b0; drive(1'b0, '0); out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_one: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_pc11: got v=%b pc=%h want v=0", out_valid, out_pc); end
`ifdef IFID_PERF_CNT_EN
    checks++; if (flush_count !== f0 + 16'd2) begin errors++; $display("FAIL flush_count: got %0d want %0d", flush_count, f0 + 16'd2); end
`endif
  endtask

  task automatic test_hold();
`ifdef IFID_PERF_CNT_EN
    logic [15:0] s0 = stall_cycles;
`endif
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 9'h1A; in_inst = 32'hDEAD_BEEF;
    tick();
    drive(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 9'h1A || out_inst !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b pc=%h inst=%h want v=1 pc=01a inst=deadbeef", i, out_valid, out_pc, out_inst);
      end
    end
`ifdef IFID_PERF_CNT_EN
    checks++; if (stall_cycles !== s0 + 16'd3) begin errors++; $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, s0 + 16'd3); end
`endif
    out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got v=%b want 0", out_valid); end
  endtask

`ifdef IFID_PERF_CNT_EN
  task automatic test_saturate();
    out_ready = 1'b0;
    drive(1'b1, 9'd3); tick();
    drive(1'b0, '0);
    force dut.r_stall_cycles = 16'hFFFE;
    #1;
    release dut.r_stall_cycles;
    tick(); tick(); tick();
    checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate: got %h want ffff", stall_cycles); end
    out_ready = 1'b1; tick();
  endtask
`endif

  task automatic test_reset_over_flush();
    out_ready = 1'b0;
    drive(1'b1, 9'd20); tick();
    drive(1'b1, 9'd21); tick();
    rst = 1'b1; flush = 1'b1; drive(1'b0, '0); tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_over_flush: got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready); end
`ifdef IFID_PERF_CNT_EN
    checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL rst_counters: got stall=%0d flush=%0d want 0 0", stall_cycles, flush_count); end
`endif
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_recover: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_hold();
`ifdef IFID_PERF_CNT_EN
    test_saturate();
`endif
    test_reset_over_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
